// File: rtl/ltc2387_acq_ctrl.sv
// ltc2387_acq_ctrl: conversion sequencer and DDR deserialiser for an
// LTC2387-style two-lane ADC. It issues periodic CNV pulses and a gated
// burst clock, captures da/db on every DCO edge, and publishes each sample
// with a one-cycle valid strobe. Everything runs in the fast_clk domain.
// Optional feature macro: PATTERN_CHECK_EN (alternating test-pattern checker).
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a conversion slot
// CNV_HI    | cnv held high for CNV_HIGH cycles
// WAIT_CONV | cnv low, waiting until T_CONV cycles after the CNV rise
// CLOCKING  | adc_clk toggles 1,0 for NUM_PULSES pulses, ends low
// DRAIN     | waiting for the remaining DCO edges, bounded by DCO_TIMEOUT
// DONE      | one cycle with sample_valid high, then back to IDLE
module ltc2387_acq_ctrl #(
    parameter int ADC_WIDTH   = 18,
    parameter int CNV_PERIOD  = 40,
    parameter int CNV_HIGH    = 2,
    parameter int T_CONV      = 20,
    parameter int DCO_TIMEOUT = 16
) (
    input  logic                 fast_clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 cnv,
    output logic                 adc_clk,
    input  logic                 dco,
    input  logic                 da,
    input  logic                 db,
    output logic [ADC_WIDTH-1:0] sample_data,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err,
    input  logic                 clear_err
`ifdef PATTERN_CHECK_EN
    ,
    input  logic                 pattern_chk,
    output logic                 pattern_err
`endif
);

    localparam int NUM_PAIRS  = ADC_WIDTH / 2;
    localparam int NUM_PULSES = (NUM_PAIRS + 1) / 2;
    localparam int PW = (CNV_PERIOD > 1) ? $clog2(CNV_PERIOD) : 1;
    localparam int CW = $clog2(NUM_PAIRS + 1);
    localparam int TW = $clog2(T_CONV + 2 * NUM_PULSES + DCO_TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE, CNV_HI, WAIT_CONV, CLOCKING, DRAIN, DONE
    } state_t;

    state_t                 state;
    logic [PW-1:0]          pcount;
    logic [TW-1:0]          tmr;
    logic [CW-1:0]          pair_cnt;
    logic [ADC_WIDTH-1:0]   sr;
    logic                   dco_q;
    logic                   slot;
    logic                   capture;
    logic                   drain_done;
    logic                   timeout_set;
    logic                   overrun_set;

    assign slot        = enable && (pcount == '0);
    assign capture     = ((state == CLOCKING) || (state == DRAIN)) && (dco != dco_q)
                         && (pair_cnt != CW'(NUM_PAIRS));
    assign drain_done  = (state == DRAIN) && (pair_cnt == CW'(NUM_PAIRS));
    assign timeout_set = (state == DRAIN) && (pair_cnt != CW'(NUM_PAIRS)) && (tmr == '0);
    assign overrun_set = slot && (state != IDLE);
    assign busy        = (state != IDLE);

    // Conversion-slot counter; parked at 0 while disabled so re-enable starts at once.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset)
            pcount <= '0;
        else if (!enable || (pcount == PW'(CNV_PERIOD - 1)))
            pcount <= '0;
        else
            pcount <= pcount + PW'(1);
    end

    // DCO edge detector reference.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset)
            dco_q <= 1'b0;
        else
            dco_q <= dco;
    end

    // Sequencer, shift register and sample output.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tmr          <= '0;
            cnv          <= 1'b0;
            adc_clk      <= 1'b0;
            pair_cnt     <= '0;
            sr           <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (capture) begin
                sr       <= {sr[ADC_WIDTH-3:0], da, db};
                pair_cnt <= pair_cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (slot) begin
                        state <= CNV_HI;
                        cnv   <= 1'b1;
                        tmr   <= TW'(CNV_HIGH - 1);
                    end
                end
                CNV_HI: begin
                    if (tmr == '0) begin
                        state <= WAIT_CONV;
                        cnv   <= 1'b0;
                        tmr   <= TW'(T_CONV - CNV_HIGH - 1);
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                WAIT_CONV: begin
                    if (tmr == '0) begin
                        state    <= CLOCKING;
                        adc_clk  <= 1'b1;
                        tmr      <= TW'(2 * NUM_PULSES - 1);
                        pair_cnt <= '0;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                CLOCKING: begin
                    if (tmr == '0) begin
                        // The last fall happened one cycle ago, so one cycle of
                        // the timeout window is already spent on entry to DRAIN.
                        state   <= DRAIN;
                        adc_clk <= 1'b0;
                        tmr     <= TW'(DCO_TIMEOUT - 2);
                    end else begin
                        adc_clk <= ~adc_clk;
                        tmr     <= tmr - TW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state        <= DONE;
                        sample_data  <= sr;
                        sample_valid <= 1'b1;
                    end else if (tmr == '0) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a coinciding set beats clear_err.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (overrun_set)
                overrun <= 1'b1;
            else if (clear_err)
                overrun <= 1'b0;
            if (timeout_set)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;
        end
    end

`ifdef PATTERN_CHECK_EN
    function automatic logic [ADC_WIDTH-1:0] alt_pattern();
        logic [ADC_WIDTH-1:0] w;
        for (int i = 0; i < ADC_WIDTH; i++)
            w[i] = ((i % 2) == 1);
        return w;
    endfunction

    localparam logic [ADC_WIDTH-1:0] PAT_A = alt_pattern();

    logic                 chk_q;
    logic                 pat_hi;
    logic                 pat_hi_cur;
    logic [ADC_WIDTH-1:0] pat_exp;

    // A fresh pattern_chk rise restarts the sequence at 1010..10 immediately.
    assign pat_hi_cur = (pattern_chk && !chk_q) ? 1'b1 : pat_hi;
    assign pat_exp    = pat_hi_cur ? PAT_A : ~PAT_A;

    // Alternating-pattern compare on each completed sample.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            chk_q       <= 1'b0;
            pat_hi      <= 1'b1;
            pattern_err <= 1'b0;
        end else begin
            chk_q <= pattern_chk;
            if (drain_done && pattern_chk)
                pat_hi <= ~pat_hi_cur;
            else if (pattern_chk && !chk_q)
                pat_hi <= 1'b1;
            if (drain_done && pattern_chk && (sr != pat_exp))
                pattern_err <= 1'b1;
            else if (clear_err)
                pattern_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ltc2387_acq_ctrl.sv
// Bench for ltc2387_acq_ctrl: an ADC pin model answers the burst clock with
// delayed DCO edges and serialised words; expected words go into a queue at
// each CNV rise and a monitor pops them on every sample_valid.
module tb_ltc2387_acq_ctrl;
    localparam int W           = 18;
    localparam int CNV_PERIOD  = 40;
    localparam int CNV_HIGH    = 2;
    localparam int T_CONV      = 20;
    localparam int DCO_TIMEOUT = 16;
    localparam int NUM_PAIRS   = W / 2;
    localparam int NUM_PULSES  = (NUM_PAIRS + 1) / 2;

    logic         fast_clk, reset, enable, clear_err;
    logic         cnv, adc_clk, dco, da, db;
    logic [W-1:0] sample_data;
    logic         sample_valid, busy, overrun, timeout_err;
`ifdef PATTERN_CHECK_EN
    logic         pattern_chk, pattern_err;
`endif

    ltc2387_acq_ctrl #(
        .ADC_WIDTH(W), .CNV_PERIOD(CNV_PERIOD), .CNV_HIGH(CNV_HIGH),
        .T_CONV(T_CONV), .DCO_TIMEOUT(DCO_TIMEOUT)
    ) dut (
        .fast_clk(fast_clk), .reset(reset), .enable(enable),
        .cnv(cnv), .adc_clk(adc_clk), .dco(dco), .da(da), .db(db),
        .sample_data(sample_data), .sample_valid(sample_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err), .clear_err(clear_err)
`ifdef PATTERN_CHECK_EN
        , .pattern_chk(pattern_chk), .pattern_err(pattern_err)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0;
    int last_fall = 0;
    int budget_next = NUM_PAIRS + 1;
    logic [W-1:0] dir_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp = '0;

    initial begin
        fast_clk = 1'b0;
        forever #5 fast_clk = ~fast_clk;
    end

    always @(posedge fast_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ADC pin model: each adc_clk edge, delayed by lat cycles, becomes one DCO
    // edge carrying the next MSB-first bit pair; edge budget allows dropouts.
    initial begin : adc_model
        logic [7:0]   hist;
        logic [W-1:0] word;
        logic         cnv_pm;
        int lat, edges_left, pair_idx;
        dco = 1'b0; da = 1'b0; db = 1'b0;
        hist = '0; word = '0; cnv_pm = 1'b0;
        lat = 0; edges_left = 0; pair_idx = 0;
        forever begin
            @(posedge fast_clk);
            #1;
            if (reset) begin
                hist = '0; edges_left = 0; cnv_pm = 1'b0;
            end else begin
                if (cnv && !cnv_pm) begin
                    if (dir_q.size() > 0) word = dir_q.pop_front();
                    else word = W'($urandom);
                    edges_left = budget_next;
                    pair_idx = 0;
                    lat = $urandom_range(0, 3);
                    if (budget_next >= NUM_PAIRS) exp_q.push_back(word);
                end
                cnv_pm = cnv;
                hist = {hist[6:0], adc_clk};
                if (edges_left > 0 && hist[lat] != hist[lat+1]) begin
                    if (pair_idx < NUM_PAIRS) begin
                        da = word[W-1-2*pair_idx];
                        db = word[W-2-2*pair_idx];
                    end else begin
                        da = 1'($urandom_range(0, 1));
                        db = 1'($urandom_range(0, 1));
                    end
                    dco = ~dco;
                    pair_idx++;
                    edges_left--;
                end
            end
        end
    end

    // Scoreboard monitor: every sample_valid pops one expected word.
    logic sv_p = 1'b0;
    always @(negedge fast_clk) begin
        if (reset) begin
            sv_p <= 1'b0;
        end else begin
            if (sample_valid) begin
                n_valid++;
                chk("valid_one_cycle", 32'(sv_p), 32'd0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: got 0x%0h, want no strobe", sample_data);
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("sample_data", 32'(sample_data), 32'(last_exp));
                end
            end
            sv_p <= sample_valid;
        end
    end

    // Pin-timing monitor: CNV width, CNV-to-clock delay, pulse count, slot spacing.
    initial begin : timing_mon
        logic cnv_p, adc_p, have_prev, en_cont, conv_ok, valid_seen;
        int rise_cyc, rises, high_len;
        cnv_p = 0; adc_p = 0; have_prev = 0; en_cont = 0; conv_ok = 0; valid_seen = 0;
        rise_cyc = 0; rises = 0; high_len = 0;
        forever begin
            @(negedge fast_clk);
            if (reset) begin
                cnv_p = 0; adc_p = 0; have_prev = 0; conv_ok = 0;
            end else begin
                if (!enable) en_cont = 0;
                if (cnv && !cnv_p) begin
                    if (have_prev && conv_ok) begin
                        chk("adc_clk_pulses", 32'(rises), 32'(NUM_PULSES));
                        if (en_cont) begin
                            if (valid_seen)
                                chk("cnv_interval", 32'(cyc - rise_cyc), 32'(CNV_PERIOD));
                            else
                                chk("cnv_interval_skip",
                                    32'(((cyc - rise_cyc) % CNV_PERIOD == 0) && (cyc - rise_cyc > CNV_PERIOD)), 32'd1);
                        end
                    end
                    rise_cyc = cyc; have_prev = 1; en_cont = 1; conv_ok = 1;
                    rises = 0; valid_seen = 0; high_len = 0;
                end
                if (cnv) high_len++;
                if (!cnv && cnv_p && conv_ok) chk("cnv_high_len", 32'(high_len), 32'(CNV_HIGH));
                if (adc_clk && !adc_p) begin
                    if (rises == 0 && conv_ok) chk("t_conv", 32'(cyc - rise_cyc), 32'(T_CONV));
                    rises++;
                end
                if (!adc_clk && adc_p) last_fall = cyc;
                if (sample_valid) valid_seen = 1;
                cnv_p = cnv; adc_p = adc_clk;
            end
        end
    end

    task automatic wait_valids(input int n, input int budget);
        int start = n_valid;
        int k = 0;
        while (n_valid < start + n && k < budget) begin
            @(negedge fast_clk);
            k++;
        end
        if (n_valid < start + n) begin
            total++; bad++;
            $display("FAIL wait_valids: got %0d strobes, want %0d", n_valid - start, n);
        end
    endtask

    task automatic wait_cnv_rise(input int budget, output int at);
        int k = 0;
        @(negedge fast_clk);
        while (cnv && k < budget) begin @(negedge fast_clk); k++; end
        while (!cnv && k < budget) begin @(negedge fast_clk); k++; end
        at = cyc;
        if (!cnv) begin
            total++; bad++;
            $display("FAIL wait_cnv_rise: got no rise within %0d cycles, want one", budget);
        end
    endtask

    task automatic wait_until_cyc(input int target);
        while (cyc < target) @(negedge fast_clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int e, t, n;
        reset = 1'b1; enable = 1'b0; clear_err = 1'b0;
`ifdef PATTERN_CHECK_EN
        pattern_chk = 1'b0;
`endif
        repeat (3) @(negedge fast_clk);
        chk("rst_cnv", 32'(cnv), 0);
        chk("rst_adc_clk", 32'(adc_clk), 0);
        chk("rst_sample_data", 32'(sample_data), 0);
        chk("rst_sample_valid", 32'(sample_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
`ifdef PATTERN_CHECK_EN
        chk("rst_pattern_err", 32'(pattern_err), 0);
`endif

        // Alternating words, then random words.
        dir_q.push_back(18'h2AAAA); dir_q.push_back(18'h15555);
        dir_q.push_back(18'h2AAAA); dir_q.push_back(18'h15555);
        reset = 1'b0; enable = 1'b1;
        wait_valids(4, 250);
        chk("overrun_clean", 32'(overrun), 0);
        chk("timeout_clean", 32'(timeout_err), 0);
        wait_valids(6, 400);

        // Dropped DCO edges: timeout, overrun set beating a concurrent clear.
        budget_next = 7;
        wait_cnv_rise(60, e);
        budget_next = NUM_PAIRS + 1;
        wait_until_cyc(e + CNV_PERIOD - 1);
        chk("overrun_before_slot", 32'(overrun), 0);
        clear_err = 1'b1;
        @(negedge fast_clk);
        chk("overrun_set_wins", 32'(overrun), 1);
        chk("no_cnv_busy_slot", 32'(cnv), 0);
        clear_err = 1'b0;
        n = 0;
        while (!timeout_err && n < 40) begin @(negedge fast_clk); n++; end
        t = cyc;
        chk("timeout_err_set", 32'(timeout_err), 1);
        chk("timeout_delay", 32'(t - last_fall), 32'(DCO_TIMEOUT));
        chk("timeout_keeps_data", 32'(sample_data), 32'(last_exp));
        chk("overrun_sticky", 32'(overrun), 1);
        @(negedge fast_clk); clear_err = 1'b1;
        @(negedge fast_clk); clear_err = 1'b0;
        chk("overrun_cleared", 32'(overrun), 0);
        chk("timeout_cleared", 32'(timeout_err), 0);

        // Reset in the middle of the clock burst.
        wait_cnv_rise(100, e);
        wait_until_cyc(e + 24);
        chk("pre_rst_adc_clk", 32'(adc_clk), 1);
        chk("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_cnv", 32'(cnv), 0);
        chk("async_rst_adc_clk", 32'(adc_clk), 0);
        chk("async_rst_busy", 32'(busy), 0);
        exp_q.delete();
        repeat (2) @(negedge fast_clk);
        reset = 1'b0;
        @(negedge fast_clk);
        chk("cnv_first_cycle_after_rst", 32'(cnv), 1);
        wait_valids(3, 200);

        // enable falls mid-conversion: it still completes, then no slots.
        wait_cnv_rise(60, e);
        repeat (5) @(negedge fast_clk);
        enable = 1'b0;
        wait_valids(1, 60);
        n = 0;
        repeat (60) begin @(negedge fast_clk); if (cnv) n++; end
        chk("no_cnv_disabled", 32'(n), 0);
        chk("idle_disabled", 32'(busy), 0);
        enable = 1'b1;
        @(negedge fast_clk);
        chk("cnv_first_cycle_enable", 32'(cnv), 1);
        wait_valids(2, 150);

`ifdef PATTERN_CHECK_EN
        enable = 1'b0;
        repeat (60) @(negedge fast_clk);
        pattern_chk = 1'b1;
        dir_q.push_back(18'h2AAAA); dir_q.push_back(18'h2AAAA);
        enable = 1'b1;
        wait_valids(1, 80);
        chk("pattern_first_ok", 32'(pattern_err), 0);
        wait_valids(1, 80);
        chk("pattern_second_err", 32'(pattern_err), 1);
`endif

        enable = 1'b0;
        repeat (60) @(negedge fast_clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ltc2387_acq_ctrl.md
Name: ltc2387_acq_ctrl

Overview:
Sequencing controller for an LTC2387-style two-lane DDR ADC (or its simulation model).
- Issues periodic CNV pulses and the gated burst clock to the ADC.
- Deserialises da/db on every DCO edge.
- Publishes each completed sample word with a one-cycle valid strobe.
- Sits between the ADC pins and the sample-processing datapath; runs entirely in the fast_clk domain.

Parameters:
ADC_WIDTH, 18, sample width in bits; must be even; NUM_PAIRS = ADC_WIDTH/2, NUM_PULSES = ceil(NUM_PAIRS/2).
CNV_PERIOD, 40, fast_clk cycles between CNV rising edges; must be >= 4.
CNV_HIGH, 2, CNV high time in fast_clk cycles; 1..CNV_PERIOD-1.
T_CONV, 20, fast_clk cycles from CNV rising edge to the first adc_clk rising edge; must be > CNV_HIGH.
DCO_TIMEOUT, 16, fast_clk cycles allowed after the last adc_clk falling edge for the remaining DCO edges.

Ports:
fast_clk  input  1  controller clock
reset  input  1  async active-high reset
enable  input  1  level; 1 = periodic acquisition running
cnv  output  1  conversion start to ADC
adc_clk  output  1  gated burst clock to ADC
dco  input  1  data clock echoed by ADC
da  input  1  lane A (odd bits, MSB first)
db  input  1  lane B (even bits)
sample_data  output  ADC_WIDTH  last completed sample; held until the next one completes
sample_valid  output  1  one-cycle strobe when sample_data updates
busy  output  1  high in any state other than IDLE
overrun  output  1  sticky; a period elapsed while still busy
timeout_err  output  1  sticky; DCO edges missing at timeout
clear_err  input  1  synchronous clear of overrun and timeout_err

Behaviour:
- Reset: decided as async active-high reset on fast_clk.
- All outputs are 0 in reset; state = IDLE; period counter = 0; shift register = 0.
- Period counter:
  - Runs only while enable = 1; counts 0..CNV_PERIOD-1 and wraps.
  - Count 0 is a conversion slot. When enable falls, the counter is held at 0, so the next enable issues CNV on its first cycle.
- Slot while state = IDLE: start a conversion (IDLE -> CNV_HI).
- Slot while busy:
  - Set overrun to 1. No CNV is issued and the current conversion continues.
  - If clear_err is asserted in the same cycle, overrun is still set (the set wins).
- FSM states:
  - IDLE
  - CNV_HI: cnv = 1 for CNV_HIGH cycles.
  - WAIT_CONV: cnv = 0; wait until T_CONV cycles have elapsed since CNV rose.
  - CLOCKING: adc_clk toggles 1,0 per fast_clk cycle for NUM_PULSES pulses (2*NUM_PULSES cycles); ends low.
  - DRAIN: wait for the remaining DCO edges.
  - DONE: one cycle; assert sample_valid and load sample_data; then go to IDLE.
- DCO capture:
  - dco_q is dco registered in fast_clk; an edge is dco != dco_q.
  - Capture is armed from entry to CLOCKING. On each edge while armed, shift {da,db} into the LSBs: sr <= {sr[W-3:0], da, db}.
  - The first captured pair is D[W-1], D[W-2].
  - Capture stops after NUM_PAIRS edges; any surplus edge (odd NUM_PAIRS) is ignored.
- DRAIN exit:
  - When the pair count reaches NUM_PAIRS, go to DONE.
  - If DCO_TIMEOUT cycles pass without reaching NUM_PAIRS, set timeout_err, return to IDLE, and leave sample_data and sample_valid untouched.
  - If the count reaches NUM_PAIRS during CLOCKING, DRAIN lasts one cycle.
- enable falling mid-conversion: the current conversion completes normally; no new slots occur.
- reset mid-conversion: immediate return to IDLE; cnv and adc_clk go low in the same instant (async).
- clear_err clears both sticky flags, except when a set condition coincides in that cycle (set has priority).
- Latency: sample_valid rises 1 cycle after the cycle in which the final pair is shifted in.

Optional Feature:
Macro PATTERN_CHECK_EN.
- Defined: adds input pattern_chk (1 bit) and output pattern_err (1 bit, sticky, cleared by clear_err).
- While pattern_chk = 1, each completed sample is compared against an expected word that alternates 1010..10 (0x2AAAA at 18 bits) and 0101..01 (0x15555). The expected word starts at 1010..10 after reset or when pattern_chk rises, and toggles after every compared sample.
- Any mismatch sets pattern_err on the sample_valid cycle.
- Not defined: neither port exists and there is no compare logic; all other behaviour is identical.

Test Plan:
- Defaults; enable = 1; ADC model returns 0x2AAAA -> cnv high for cycles 0-1; adc_clk 5 pulses starting at cycle 20; sample_data = 0x2AAAA with a one-cycle sample_valid; next cnv at cycle 40.
- Model alternates 0x2AAAA/0x15555 for 4 conversions -> 4 sample_valid strobes 40 cycles apart with values alternating; overrun = 0, timeout_err = 0.
- CNV_PERIOD = 25 -> slot at cycle 25 occurs while busy: overrun = 1, no cnv at 25; next cnv at 50; clear_err pulse -> overrun = 0.
- Model sends only 7 DCO edges -> timeout_err = 1 16 cycles after the last adc_clk fall; no sample_valid; sample_data keeps its previous value.
- Reset asserted at cycle 24 (mid-CLOCKING) -> cnv = 0, adc_clk = 0, busy = 0 immediately; after release with enable = 1, cnv rises on the first cycle.
- PATTERN_CHECK_EN, pattern_chk = 1, model sends 0x2AAAA, 0x2AAAA -> pattern_err = 0 after the first sample, 1 after the second.
